// File: rtl/rvv_issue_pkg.sv
// rtl/rvv_issue_pkg.sv - shared types and constants for the RVV instruction issuer
package rvv_issue_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP
  } issue_state_t;

  localparam logic [63:0] NOP_INSN    = '0;
  localparam int          ISSUE_CNT_W = 16;

endpackage

// File: rtl/rvv_sync_fifo.sv
// rtl/rvv_sync_fifo.sv - synchronous FIFO with flush, occupancy count and full/empty flags
module rvv_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // The extra pointer MSB separates a full buffer from an empty one.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rvv_insn_issuer.sv
// rtl/rvv_insn_issuer.sv - buffers host RVV instructions and issues them to the core with NOP gaps
module rvv_insn_issuer
  import rvv_issue_pkg::*;
#(
  parameter int INSN_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int GAP        = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSN_WIDTH-1:0]  host_insn,
  input  logic                   host_valid,
  output logic                   host_ready,
  input  logic                   flush,
  input  logic                   core_stall,
  output logic [INSN_WIDTH-1:0]  insn_out,
  output logic                   insn_out_valid,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [15:0]            issued_count
);

  localparam logic [INSN_WIDTH-1:0] NOP      = NOP_INSN[INSN_WIDTH-1:0];
  localparam logic [3:0]            GAP_LOAD = GAP[3:0];

  issue_state_t            state_q;
  issue_state_t            state_d;
  logic [3:0]              gap_q;
  logic [3:0]              gap_d;
  logic                    take;
  logic                    pop;
  logic                    push;
  logic                    can_issue;
  logic [INSN_WIDTH-1:0]   insn_d;
  logic [INSN_WIDTH-1:0]   fifo_dout;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [ISSUE_CNT_W-1:0]  issued_q;

  // Ready comes from the registered occupancy only, so a pop never frees a slot the same cycle.
  assign host_ready   = !fifo_full && rst;
  assign push         = host_valid && host_ready;
  assign can_issue    = !fifo_empty && !core_stall;
  assign issued_count = issued_q;

  rvv_sync_fifo #(
    .WIDTH (INSN_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (host_insn),
    .pop   (pop),
    .flush (flush),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The last gap cycle behaves like idle, so GAP counts the NOP cycles between instructions.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    take    = 1'b0;
    case (state_q)
      S_IDLE: take = can_issue;
      S_ISSUE: begin
        if (GAP == 0) begin
          take = can_issue;
          if (!can_issue) state_d = S_IDLE;
        end else begin
          gap_d   = GAP_LOAD;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q <= 4'd1) begin
          gap_d = '0;
          take  = can_issue;
          if (!can_issue) state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      gap_d   = '0;
      take    = 1'b0;
    end
    if (take) state_d = S_ISSUE;
    pop    = take;
    insn_d = take ? fifo_dout : NOP;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      gap_q          <= '0;
      insn_out       <= NOP;
      insn_out_valid <= 1'b0;
      issued_q       <= '0;
    end else begin
      state_q        <= state_d;
      gap_q          <= gap_d;
      insn_out       <= insn_d;
      insn_out_valid <= take;
      // An instruction on insn_out during its issue cycle is delivered, flush or not.
      if (state_q == S_ISSUE) issued_q <= issued_q + 16'd1;
    end
  end

endmodule
